// File: rtl/insn_code_decoder_pkg.sv
// rtl/insn_code_decoder_pkg.sv - RV32I opcode classes, decoded-entry type and decode-stage FSM states
package rv32i_code_pkg;

    localparam int CODE_WIDTH = 10;
    localparam int ENTRY_PC_W = 32;

    localparam int CODE_J      = 0;
    localparam int CODE_JALR   = 1;
    localparam int CODE_LUI    = 2;
    localparam int CODE_AUIPC  = 3;
    localparam int CODE_BRANCH = 4;
    localparam int CODE_ROP    = 5;
    localparam int CODE_STORE  = 6;
    localparam int CODE_IALU   = 7;
    localparam int CODE_LOAD   = 8;
    localparam int CODE_CSR    = 9;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ROP    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0]            insn;
        logic [ENTRY_PC_W-1:0]  pc;
        logic [CODE_WIDTH-1:0]  code;
        logic                   illegal;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/insn_code_decoder_if.sv
// rtl/insn_code_decoder_if.sv - fetch-side and control-side handshake bundle of the decode stage
interface insn_code_decoder_if #(
    parameter int PC_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_insn;
    logic [PC_W-1:0]    in_pc;
    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_insn;
    logic [PC_W-1:0]    out_pc;
    logic [9:0]         out_code;
    logic [2:0]         out_func3;
    logic               out_illegal;

    modport slave (
        input  in_valid, in_insn, in_pc, out_ready,
        output in_ready, out_valid, out_insn, out_pc, out_code, out_func3, out_illegal
    );

    modport master (
        output in_valid, in_insn, in_pc, out_ready,
        input  in_ready, out_valid, out_insn, out_pc, out_code, out_func3, out_illegal
    );
endinterface

// File: rtl/insn_code_decoder_class_lut.sv
// rtl/insn_code_decoder_class_lut.sv - opcode to one-hot CODE/ILLEGAL lookup
// CSR_DECODE_EN selects whether SYSTEM (1110011) decodes to CODE bit 9 or is flagged illegal.
module insn_class_lut
    import rv32i_code_pkg::*;
(
    input  logic [6:0]              i_opcode,
    output logic [CODE_WIDTH-1:0]   o_code,
    output logic                    o_illegal
);

    always_comb begin
        o_code    = '0;
        o_illegal = 1'b0;
        if (i_opcode[1:0] != 2'b11) begin
            o_illegal = 1'b1;
        end else begin
            case (i_opcode)
                OP_JAL:    o_code[CODE_J]      = 1'b1;
                OP_JALR:   o_code[CODE_JALR]   = 1'b1;
                OP_LUI:    o_code[CODE_LUI]    = 1'b1;
                OP_AUIPC:  o_code[CODE_AUIPC]  = 1'b1;
                OP_BRANCH: o_code[CODE_BRANCH] = 1'b1;
                OP_ROP:    o_code[CODE_ROP]    = 1'b1;
                OP_STORE:  o_code[CODE_STORE]  = 1'b1;
                OP_IALU:   o_code[CODE_IALU]   = 1'b1;
                OP_LOAD:   o_code[CODE_LOAD]   = 1'b1;
`ifdef CSR_DECODE_EN
                OP_SYSTEM: o_code[CODE_CSR]    = 1'b1;
`else
                OP_SYSTEM: o_illegal           = 1'b1;
`endif
                default:   o_illegal           = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/insn_code_decoder.sv
// rtl/insn_code_decoder.sv - registered RV32I class decode stage with a 2-entry head/skid buffer
// Optional SYSTEM decode is controlled by CSR_DECODE_EN inside insn_class_lut.
module insn_code_decoder
    import rv32i_code_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int CODE_W = 10
)(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_flush,
    insn_code_decoder_if.slave  bus
);

    if (CODE_W != CODE_WIDTH) begin : g_code_w_check
        $error("insn_code_decoder: CODE_W must be 10");
    end
    if (PC_W > ENTRY_PC_W) begin : g_pc_w_check
        $error("insn_code_decoder: PC_W exceeds entry PC width");
    end

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_in_ready;
    entry_t                 r_head;
    entry_t                 r_skid;
    entry_t                 w_new;
    logic [CODE_WIDTH-1:0]  w_code;
    logic                   w_illegal;
    logic                   w_accept;
    logic                   w_emit;
    logic                   w_head_we;
    logic                   w_head_from_skid;
    logic                   w_skid_we;

    insn_class_lut u_lut (
        .i_opcode  (bus.in_insn[6:0]),
        .o_code    (w_code),
        .o_illegal (w_illegal)
    );

    assign w_new = '{insn: bus.in_insn, pc: ENTRY_PC_W'(bus.in_pc), code: w_code, illegal: w_illegal};

    assign w_accept = bus.in_valid & r_in_ready;
    assign w_emit   = (r_state != ST_EMPTY) & bus.out_ready;

    // IN_READY is registered from the next state so fetch never sees a combinational path
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_FULL);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_next_state = ST_ONE;
            ST_ONE: begin
                if (w_accept && !w_emit)      w_next_state = ST_FULL;
                else if (!w_accept && w_emit) w_next_state = ST_EMPTY;
            end
            ST_FULL:  if (w_emit) w_next_state = ST_ONE;
            default:  w_next_state = ST_EMPTY;
        endcase
        if (i_flush) w_next_state = ST_EMPTY;
    end

    always_comb begin
        w_head_we        = 1'b0;
        w_head_from_skid = 1'b0;
        w_skid_we        = 1'b0;
        case (r_state)
            ST_EMPTY: w_head_we = w_accept;
            ST_ONE: begin
                w_head_we = w_accept & w_emit;
                w_skid_we = w_accept & ~w_emit;
            end
            ST_FULL: begin
                w_head_we        = w_emit;
                w_head_from_skid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head <= '0;
            r_skid <= '0;
        end else begin
            if (w_head_we) r_head <= w_head_from_skid ? r_skid : w_new;
            if (w_skid_we) r_skid <= w_new;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = (r_state != ST_EMPTY);
    assign bus.out_insn    = r_head.insn;
    assign bus.out_pc      = r_head.pc[PC_W-1:0];
    assign bus.out_code    = r_head.code;
    assign bus.out_func3   = r_head.insn[14:12];
    assign bus.out_illegal = r_head.illegal;

endmodule

// File: tb/tb_insn_code_decoder.sv
// tb/tb_insn_code_decoder.sv - directed table-driven bench for insn_code_decoder
module tb_insn_code_decoder;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    insn_code_decoder_if #(.PC_W(32)) bus ();

    insn_code_decoder #(.PC_W(32), .CODE_W(10)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_flush (flush),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] insn;
        logic [9:0]  exp_code;
        logic        exp_illegal;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] insn, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_insn  = insn;
        bus.in_pc    = pc;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h0000_506F, 10'b00_0000_0001, 1'b0};
        vecs[1]  = '{32'h0000_5067, 10'b00_0000_0010, 1'b0};
        vecs[2]  = '{32'h0000_5037, 10'b00_0000_0100, 1'b0};
        vecs[3]  = '{32'h0000_5017, 10'b00_0000_1000, 1'b0};
        vecs[4]  = '{32'h0000_5063, 10'b00_0001_0000, 1'b0};
        vecs[5]  = '{32'h0000_5033, 10'b00_0010_0000, 1'b0};
        vecs[6]  = '{32'h0000_5023, 10'b00_0100_0000, 1'b0};
        vecs[7]  = '{32'h0000_5013, 10'b00_1000_0000, 1'b0};
        vecs[8]  = '{32'h0000_5003, 10'b01_0000_0000, 1'b0};
`ifdef CSR_DECODE_EN
        vecs[9]  = '{32'h0000_5073, 10'b10_0000_0000, 1'b0};
        vecs[12] = '{32'h3000_2073, 10'b10_0000_0000, 1'b0};
`else
        vecs[9]  = '{32'h0000_5073, 10'b00_0000_0000, 1'b1};
        vecs[12] = '{32'h3000_2073, 10'b00_0000_0000, 1'b1};
`endif
        vecs[10] = '{32'h0000_0000, 10'b00_0000_0000, 1'b1};
        vecs[11] = '{32'h0000_0010, 10'b00_0000_0000, 1'b1};
        vecs[13] = '{32'h0000_000F, 10'b00_0000_0000, 1'b1};

        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_insn   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("rst_in_ready",  64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_insn",  64'(bus.out_insn), 64'd0);
        check("rst_out_pc",    64'(bus.out_pc), 64'd0);
        check("rst_out_code",  64'(bus.out_code), 64'd0);
        check("rst_out_func3", 64'(bus.out_func3), 64'd0);
        check("rst_out_ill",   64'(bus.out_illegal), 64'd0);
        rst = 1'b0;
        step();
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // classification table, streamed back-to-back with the consumer always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            push(vecs[i].insn, 32'h1000 + 32'(i * 4));
            check($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("v%0d_insn", i),  64'(bus.out_insn), 64'(vecs[i].insn));
            check($sformatf("v%0d_pc", i),    64'(bus.out_pc), 64'(32'h1000 + 32'(i * 4)));
            check($sformatf("v%0d_code", i),  64'(bus.out_code), 64'(vecs[i].exp_code));
            check($sformatf("v%0d_ill", i),   64'(bus.out_illegal), 64'(vecs[i].exp_illegal));
            check($sformatf("v%0d_func3", i), 64'(bus.out_func3), 64'(vecs[i].insn[14:12]));
        end
        step();
        check("drain_out_valid", 64'(bus.out_valid), 64'd0);

        // back-pressure: fill both entries, then drain in order
        bus.out_ready = 1'b0;
        push(32'h0000_2003, 32'h100);
        check("bp_a_valid",    64'(bus.out_valid), 64'd1);
        check("bp_one_ready",  64'(bus.in_ready), 64'd1);
        push(32'h0000_0033, 32'h104);
        check("bp_full_ready", 64'(bus.in_ready), 64'd0);
        check("bp_hold_a",     64'(bus.out_insn), 64'h0000_2003);
        bus.in_valid = 1'b1;
        bus.in_insn  = 32'h0000_006F;
        bus.in_pc    = 32'h108;
        step();
        bus.in_valid = 1'b0;
        check("bp_hold_a2",    64'(bus.out_insn), 64'h0000_2003);
        check("bp_hold_pc",    64'(bus.out_pc), 64'h100);
        check("bp_hold_code",  64'(bus.out_code), 64'b01_0000_0000);
        bus.out_ready = 1'b1;
        step();
        check("bp_b_insn",     64'(bus.out_insn), 64'h0000_0033);
        check("bp_b_pc",       64'(bus.out_pc), 64'h104);
        check("bp_b_code",     64'(bus.out_code), 64'b00_0010_0000);
        check("bp_b_ready",    64'(bus.in_ready), 64'd1);
        step();
        check("bp_empty",      64'(bus.out_valid), 64'd0);

        // flush while full, with an offer in the same cycle
        bus.out_ready = 1'b0;
        push(32'h0000_2003, 32'h200);
        push(32'h0000_0033, 32'h204);
        flush         = 1'b1;
        bus.out_ready = 1'b1;
        push(32'h0000_006F, 32'h208);
        flush = 1'b0;
        check("fl_out_valid",  64'(bus.out_valid), 64'd0);
        check("fl_in_ready",   64'(bus.in_ready), 64'd1);
        step();
        check("fl_no_emit",    64'(bus.out_valid), 64'd0);

        // flush in ONE with a simultaneous accept also discards the offer
        push(32'h0000_0013, 32'h300);
        flush = 1'b1;
        push(32'h0000_0037, 32'h304);
        flush = 1'b0;
        check("fl1_out_valid", 64'(bus.out_valid), 64'd0);

        // reset with two entries held
        bus.out_ready = 1'b0;
        push(32'h0000_2003, 32'h400);
        push(32'h0000_0033, 32'h404);
        rst = 1'b1;
        step();
        check("rr_out_valid",  64'(bus.out_valid), 64'd0);
        check("rr_in_ready",   64'(bus.in_ready), 64'd0);
        check("rr_out_insn",   64'(bus.out_insn), 64'd0);
        check("rr_out_pc",     64'(bus.out_pc), 64'd0);
        check("rr_out_code",   64'(bus.out_code), 64'd0);
        check("rr_out_func3",  64'(bus.out_func3), 64'd0);
        check("rr_out_ill",    64'(bus.out_illegal), 64'd0);
        rst = 1'b0;
        step();
        check("rr_post_ready", 64'(bus.in_ready), 64'd1);
        check("rr_post_valid", 64'(bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
